// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle arithmetic/logic/compare ops plus an iterative
// 1-bit-per-cycle shifter, with valid/ready handshakes on request and result sides.
module alu_exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_sel,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              neg,
  output logic              carry,
  output logic              ovf,
  output logic              illegal,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Requesters
  // hold a request until accepted; result and flags stay stable until consumed.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [XLEN-1:0]      r_acc;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_shop;

  logic                 w_accept;
  logic                 w_is_sub;
  logic                 w_is_arith;
  logic                 w_is_shift;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [XLEN-1:0]      w_b_eff;
  logic [XLEN:0]        w_sum;
  logic                 w_ovf;
  logic [XLEN-1:0]      w_res;
  logic                 w_illegal;
  logic [XLEN-1:0]      w_shift_next;

  assign in_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign dbg_state  = r_state;

  assign w_is_sub   = (alu_sel == 4'b0001) || (alu_sel == 4'b0010);
  assign w_is_arith = (alu_sel == 4'b0000) || w_is_sub;
  assign w_is_shift = (alu_sel == 4'b1000) || (alu_sel == 4'b1001) || (alu_sel == 4'b1010);
  assign w_shamt    = op_b[SHAMT_W-1:0];

  // Subtraction is a + ~b + 1, so carry-out means "no borrow" (a >= b unsigned).
  assign w_b_eff = w_is_sub ? ~op_b : op_b;
  assign w_sum   = {1'b0, op_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};
  assign w_ovf   = (op_a[XLEN-1] == w_b_eff[XLEN-1]) && (w_sum[XLEN-1] != op_a[XLEN-1]);

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (alu_sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: w_res = w_sum[XLEN-1:0];
      4'b1011: w_res = {w_sum[XLEN-1:1], 1'b0};
      4'b0100: w_res = op_a | op_b;
      4'b0101: w_res = op_a & op_b;
      4'b0111: w_res = op_a ^ op_b;
      4'b0110: w_res = op_b;
      4'b1000, 4'b1001, 4'b1010: w_res = op_a;  // only reached with a zero shift amount
      4'b1101: w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1111: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: begin
        w_res     = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_shift_next = r_acc;
    case (r_shop)
      2'b00:   w_shift_next = {1'b0, r_acc[XLEN-1:1]};
      2'b01:   w_shift_next = {r_acc[XLEN-2:0], 1'b0};
      default: w_shift_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_shop    <= 2'b00;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_acc   <= op_a;
              r_cnt   <= w_shamt;
              r_shop  <= alu_sel[1:0];
              r_state <= ST_SHIFT;
            end else begin
              result    <= w_res;
              zero      <= (w_res == '0);
              neg       <= w_res[XLEN-1];
              carry     <= w_is_arith & w_sum[XLEN];
              ovf       <= w_is_arith & w_ovf;
              illegal   <= w_illegal;
              out_valid <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_acc <= w_shift_next;
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            result    <= w_shift_next;
            zero      <= (w_shift_next == '0);
            neg       <= w_shift_next[XLEN-1];
            carry     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus randomized ops against a
// plain-arithmetic reference model, with an expected-result queue.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, neg, carry, ovf, illegal;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {illegal, ovf, carry, neg, zero, result[31:0]}
  function automatic logic [36:0] model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v, il;
    longint sa, sb, ss;
    r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s)
      4'd0: begin
        r  = a + b;
        c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        ss = sa + sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1, 4'd2: begin
        r  = a - b;
        c  = (a >= b);
        ss = sa - sb;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd3:  r = a + b;
      4'd11: r = (a + b) & 32'hFFFF_FFFE;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd7:  r = a ^ b;
      4'd6:  r = b;
      4'd8:  r = a >> b[4:0];
      4'd9:  r = a << b[4:0];
      4'd10: r = $unsigned($signed(a) >>> b[4:0]);
      4'd13: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd15: r = (a < b) ? 32'd1 : 32'd0;
      default: il = 1'b1;
    endcase
    return {il, v, c, r[31], (r == 32'd0), r};
  endfunction

  function automatic int model_lat(input logic [3:0] s, input logic [31:0] b);
    if ((s == 4'd8 || s == 4'd9 || s == 4'd10) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, holds it until accepted, returns at the negedge of cycle 1.
  task automatic send(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_sel = s; op_a = a; op_b = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    alu_sel  = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  // Waits for out_valid from cycle 1 onward and checks against the queue head.
  task automatic check_out(input string tag, input int exp_lat);
    int lat;
    logic [36:0] e;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'd0;
    chk({tag, "_result"}, result, e[31:0]);
    chk({tag, "_flags"}, {27'd0, illegal, ovf, carry, neg, zero}, {27'd0, e[36:32]});
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(s, a, b));
    send(s, a, b);
    check_out(tag, model_lat(s, b));
    release_out();
  endtask

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_sel = 4'd0; op_a = 32'd0; op_b = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'd0, illegal, ovf, carry, neg, zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset aborts a shift in progress
    send(4'd9, 32'd1, 32'd31);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);

    // Directed operations
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_op("sub_ovf", 4'd2, 32'h8000_0000, 32'd1);
    run_op("sub_borrow", 4'd1, 32'd1, 32'd2);
    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    run_op("sra4", 4'd10, 32'h8000_0000, 32'd4);
    run_op("srl4", 4'd8, 32'h8000_0000, 32'd4);
    run_op("sll0", 4'd9, 32'd3, 32'd0);
    run_op("sll31", 4'd9, 32'd1, 32'd31);
    run_op("slt", 4'd13, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'd15, 32'hFFFF_FFFF, 32'd1);
    run_op("lui", 4'd6, 32'hDEAD_BEEF, 32'h1234_5000);
    run_op("jalr", 4'd11, 32'h1001, 32'h4);
    run_op("jal", 4'd3, 32'h1001, 32'h4);

    // Backpressure: result held, new request waits for the consume edge
    exp_q.push_back(model(4'd7, 32'hF0F0, 32'hFF00));
    send(4'd7, 32'hF0F0, 32'hFF00);
    check_out("xor", 1);
    in_valid = 1'b1; alu_sel = 4'd0; op_a = 32'd5; op_b = 32'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_result", result, 32'h0000_0FF0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_released_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(model(4'd0, 32'd5, 32'd6));
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_next", 1);
    release_out();

    // Illegal code, then a legal op clears the flag
    run_op("illegal_c", 4'd12, 32'h1234, 32'h5678);
    run_op("after_illegal", 4'd4, 32'h00F0, 32'h0F00);
    run_op("illegal_e", 4'd14, 32'hFFFF_FFFF, 32'h0);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op("rand", rs, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
